// File: rtl/md_issue_ctrl.sv
// Multiply/divide issue control: md_start, busy and stall_d are combinational, and a run occupies MUL_LAT/DIV_LAT cycles after the start edge.
// stall_d holds an md-using D-stage instruction while busy; a start seen while busy is dropped and sets a sticky issue_err.
module md_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_md_use,
  input  logic        e_md_start,
  input  logic        e_is_div,
  input  logic        flush_req,
  output logic        md_start,
  output logic        md_enable,
  output logic        busy,
  output logic        stall_d,
  output logic        md_done,
  output logic        issue_err,
  output logic [31:0] stall_cnt
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = ($clog2(MAX_LAT + 1) < 4) ? 4 : $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (md_start) begin
          state_nxt = e_is_div ? DIV_RUN : MUL_RUN;
          count_nxt = e_is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end
      end
      default: begin
        // A flush never shortens a run; the HI/LO unit finishes regardless.
        if (count <= CW'(1)) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else begin
          count_nxt = count - CW'(1);
        end
      end
    endcase
  end

  // Gating with reset keeps the strobes low while reset is held, whatever the inputs.
  always_comb begin
    md_start  = reset & e_md_start & ~flush_req & (state == IDLE);
    md_enable = ~flush_req;
    busy      = (state != IDLE) | md_start;
    stall_d   = d_md_use & busy;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_done   <= 1'b0;
      issue_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      md_done <= (state != IDLE) && (count <= CW'(1));
      if (e_md_start && !flush_req && (state != IDLE))
        issue_err <= 1'b1;
      if (stall_d)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: drives one cycle at a time and compares outputs against hand-computed values.
module tb_md_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        d_md_use;
  logic        e_md_start;
  logic        e_is_div;
  logic        flush_req;
  logic        md_start;
  logic        md_enable;
  logic        busy;
  logic        stall_d;
  logic        md_done;
  logic        issue_err;
  logic [31:0] stall_cnt;

  int n_vec;
  int n_err;

  md_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_md_use   (d_md_use),
    .e_md_start (e_md_start),
    .e_is_div   (e_is_div),
    .flush_req  (flush_req),
    .md_start   (md_start),
    .md_enable  (md_enable),
    .busy       (busy),
    .stall_d    (stall_d),
    .md_done    (md_done),
    .issue_err  (issue_err),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; d_md_use = 1'b1; e_md_start = 1'b1; e_is_div = 1'b0; flush_req = 1'b0;
    #1;
    n_vec++; if (md_start !== 1'b0) begin n_err++; $display("FAIL reset_md_start: got %b want 0", md_start); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL reset_stall_d: got %b want 0", stall_d); end
    step();
    n_vec++; if (md_done !== 1'b0) begin n_err++; $display("FAIL reset_md_done: got %b want 0", md_done); end
    n_vec++; if (issue_err !== 1'b0) begin n_err++; $display("FAIL reset_issue_err: got %b want 0", issue_err); end
    n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    d_md_use = 1'b0; e_md_start = 1'b0;
    #1 reset = 1'b1;
  endtask

  task automatic test_mult();
    step();
    e_md_start = 1'b1; e_is_div = 1'b0;
    #1;
    n_vec++; if (md_start !== 1'b1) begin n_err++; $display("FAIL mult_md_start: got %b want 1", md_start); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mult_busy_c0: got %b want 1", busy); end
    n_vec++; if (md_enable !== 1'b1) begin n_err++; $display("FAIL mult_md_enable: got %b want 1", md_enable); end
    for (int i = 1; i <= 7; i++) begin
      step();
      e_md_start = 1'b0;
      #1;
      n_vec++; if (busy !== (i <= 5)) begin n_err++; $display("FAIL mult_busy_c%0d: got %b want %b", i, busy, (i <= 5)); end
      n_vec++; if (md_done !== (i == 6)) begin n_err++; $display("FAIL mult_done_c%0d: got %b want %b", i, md_done, (i == 6)); end
    end
  endtask

  task automatic test_div_stall();
    step();
    d_md_use = 1'b1; e_md_start = 1'b1; e_is_div = 1'b1;
    #1;
    n_vec++; if (stall_d !== 1'b1) begin n_err++; $display("FAIL div_stall_c0: got %b want 1", stall_d); end
    for (int i = 1; i <= 11; i++) begin
      step();
      e_md_start = 1'b0; e_is_div = 1'b0;
      #1;
      n_vec++; if (stall_d !== (i <= 10)) begin n_err++; $display("FAIL div_stall_c%0d: got %b want %b", i, stall_d, (i <= 10)); end
    end
    n_vec++; if (stall_cnt !== 32'd11) begin n_err++; $display("FAIL div_stall_cnt: got %0d want 11", stall_cnt); end
    n_vec++; if (md_done !== 1'b1) begin n_err++; $display("FAIL div_done_c11: got %b want 1", md_done); end
    step();
    d_md_use = 1'b0;
    #1;
    n_vec++; if (stall_cnt !== 32'd11) begin n_err++; $display("FAIL div_stall_cnt_hold: got %0d want 11", stall_cnt); end
  endtask

  task automatic test_flush();
    step();
    e_md_start = 1'b1; e_is_div = 1'b0; flush_req = 1'b1;
    #1;
    n_vec++; if (md_start !== 1'b0) begin n_err++; $display("FAIL flush_md_start: got %b want 0", md_start); end
    n_vec++; if (md_enable !== 1'b0) begin n_err++; $display("FAIL flush_md_enable: got %b want 0", md_enable); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", busy); end
    step();
    e_md_start = 1'b0; e_is_div = 1'b1; flush_req = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_idle_after: got %b want 0", busy); end
    n_vec++; if (md_enable !== 1'b1) begin n_err++; $display("FAIL flush_enable_back: got %b want 1", md_enable); end
    step();
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL no_start_is_div: got %b want 0", busy); end
    n_vec++; if (md_done !== 1'b0) begin n_err++; $display("FAIL flush_no_done: got %b want 0", md_done); end
    e_is_div = 1'b0;
  endtask

  task automatic test_flush_midrun();
    step();
    e_md_start = 1'b1; e_is_div = 1'b1;
    #1;
    for (int i = 1; i <= 12; i++) begin
      step();
      e_md_start = 1'b0; e_is_div = 1'b0;
      flush_req = (i == 3);
      #1;
      n_vec++; if (busy !== (i <= 10)) begin n_err++; $display("FAIL midflush_busy_c%0d: got %b want %b", i, busy, (i <= 10)); end
      n_vec++; if (md_done !== (i == 11)) begin n_err++; $display("FAIL midflush_done_c%0d: got %b want %b", i, md_done, (i == 11)); end
    end
  endtask

  task automatic test_illegal_issue();
    step();
    e_md_start = 1'b1; e_is_div = 1'b0;
    #1;
    for (int i = 1; i <= 7; i++) begin
      step();
      e_md_start = (i == 2); e_is_div = (i == 2);
      #1;
      if (i == 2) begin
        n_vec++; if (md_start !== 1'b0) begin n_err++; $display("FAIL illegal_md_start: got %b want 0", md_start); end
      end
      n_vec++; if (issue_err !== (i >= 3)) begin n_err++; $display("FAIL illegal_err_c%0d: got %b want %b", i, issue_err, (i >= 3)); end
      n_vec++; if (busy !== (i <= 5)) begin n_err++; $display("FAIL illegal_busy_c%0d: got %b want %b", i, busy, (i <= 5)); end
      n_vec++; if (md_done !== (i == 6)) begin n_err++; $display("FAIL illegal_done_c%0d: got %b want %b", i, md_done, (i == 6)); end
    end
  endtask

  task automatic test_async_reset();
    step();
    d_md_use = 1'b1; e_md_start = 1'b1; e_is_div = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      step();
      e_md_start = 1'b0; e_is_div = 1'b0;
      #1;
    end
    n_vec++; if (stall_d !== 1'b1) begin n_err++; $display("FAIL areset_pre_stall: got %b want 1", stall_d); end
    #1 reset = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_busy: got %b want 0", busy); end
    n_vec++; if (stall_d !== 1'b0) begin n_err++; $display("FAIL areset_stall_d: got %b want 0", stall_d); end
    n_vec++; if (issue_err !== 1'b0) begin n_err++; $display("FAIL areset_issue_err: got %b want 0", issue_err); end
    n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL areset_stall_cnt: got %0d want 0", stall_cnt); end
    // Release between edges with a start already presented; the next edge must take it.
    d_md_use = 1'b0; e_md_start = 1'b1; e_is_div = 1'b0;
    reset = 1'b1;
    #0.1;
    n_vec++; if (md_start !== 1'b1) begin n_err++; $display("FAIL post_reset_md_start: got %b want 1", md_start); end
    step();
    e_md_start = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL post_reset_accept: got %b want 1", busy); end
    for (int i = 2; i <= 6; i++) begin
      step();
      #1;
    end
    n_vec++; if (md_done !== 1'b1) begin n_err++; $display("FAIL post_reset_done: got %b want 1", md_done); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_mult();
    test_div_stall();
    test_flush();
    test_flush_midrun();
    test_illegal_issue();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
